// File: rtl/k_and_s_pkg.sv
// Shared types and encodings for the K&S datapath: decoded instruction set,
// 8-bit opcode values and the 3-bit ALU operation codes.
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP    = 4'd0,
      I_LOAD   = 4'd1,
      I_STORE  = 4'd2,
      I_MOVE   = 4'd3,
      I_ADD    = 4'd4,
      I_SUB    = 4'd5,
      I_AND    = 4'd6,
      I_OR     = 4'd7,
      I_BRANCH = 4'd8,
      I_BZERO  = 4'd9,
      I_BNZERO = 4'd10,
      I_BNEG   = 4'd11,
      I_BNNEG  = 4'd12,
      I_HALT   = 4'd13,
      I_MUL    = 4'd14
   } decoded_instruction_type;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_BRANCH = 8'h01;
   localparam logic [7:0] OP_BZERO  = 8'h02;
   localparam logic [7:0] OP_BNZERO = 8'h03;
   localparam logic [7:0] OP_BNEG   = 8'h04;
   localparam logic [7:0] OP_BNNEG  = 8'h05;
   localparam logic [7:0] OP_LOAD   = 8'h81;
   localparam logic [7:0] OP_STORE  = 8'h82;
   localparam logic [7:0] OP_MOVE   = 8'h83;
   localparam logic [7:0] OP_ADD    = 8'hA1;
   localparam logic [7:0] OP_SUB    = 8'hA2;
   localparam logic [7:0] OP_AND    = 8'hA3;
   localparam logic [7:0] OP_OR     = 8'hA4;
   localparam logic [7:0] OP_MUL    = 8'hA5;
   localparam logic [7:0] OP_HALT   = 8'hFF;

   localparam logic [2:0] ALU_OR  = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_MUL = 3'b100;

endpackage

// File: rtl/ks_data_path_p_mul.sv
// Sequential shift-add unsigned multiplier, one partial product per cycle.
// Only compiled when KS_DP_MUL_EN is defined.
`ifdef KS_DP_MUL_EN
module ks_seq_mul #(
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  busy,
   output logic [2*DATA_W-1:0]   product
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [2*DATA_W-1:0] mcand_r;
   logic [2*DATA_W-1:0] acc_r;
   logic [DATA_W-1:0]   mplier_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                busy_r;

   // Operand capture on an idle start, then DATA_W shift-add iterations; starts while busy are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r  <= '0;
         acc_r    <= '0;
         mplier_r <= '0;
         cnt_r    <= '0;
         busy_r   <= 1'b0;
      end else if (busy_r) begin
         if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
         end else begin
            acc_r <= acc_r;
         end
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         cnt_r    <= cnt_r + CNT_W'(1);
         if (cnt_r == CNT_W'(DATA_W - 1)) begin
            busy_r <= 1'b0;
         end else begin
            busy_r <= 1'b1;
         end
      end else if (start) begin
         mcand_r  <= {{DATA_W{1'b0}}, a};
         mplier_r <= b;
         acc_r    <= '0;
         cnt_r    <= '0;
         busy_r   <= 1'b1;
      end else begin
         busy_r   <= 1'b0;
      end
   end

   assign busy    = busy_r;
   assign product = acc_r;

endmodule
`endif

// File: rtl/ks_data_path_p.sv
// K&S datapath: IR + decoder, register file, ALU with flags, PC and address mux.
// Optional sequential multiplier enabled by defining KS_DP_MUL_EN.
module ks_data_path_p
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 4,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic                    write_reg_enable,
   input  logic                    flags_reg_enable,
   input  logic                    mul_start,
   input  logic [2:0]              operation,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic                    mul_busy,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       data_out,
   input  logic [DATA_W-1:0]       data_in
);
   localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic [DATA_W-1:0]       ir_r;
   logic [ADDR_W-1:0]       pc_r;
   logic [DATA_W-1:0]       regs_r [NREGS];
   logic [7:0]              opcode_s;
   decoded_instruction_type dec_s;
   logic [RW-1:0]           a_s, b_s, c_s;
   logic [ADDR_W-1:0]       mem_s;
   logic [DATA_W-1:0]       bus_a_s, bus_b_s, bus_c_s, ula_out_s, b_eff_s, sum_s;
   logic                    sub_s, cout_s, c_msb_s, uov_s, sov_s;
   logic                    mul_busy_s, wr_en_s, fl_en_s;

`ifdef KS_DP_MUL_EN
   logic [2*DATA_W-1:0]     product_s;

   ks_seq_mul #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (bus_a_s),
      .b       (bus_b_s),
      .busy    (mul_busy_s),
      .product (product_s)
   );
`else
   assign mul_busy_s = mul_start & 1'b0;
`endif

   // Nothing commits to the register file or flags while a multiply is in flight
   assign wr_en_s = write_reg_enable & ~mul_busy_s;
   assign fl_en_s = flags_reg_enable & ~mul_busy_s;
   assign mul_busy = mul_busy_s;

   assign opcode_s = ir_r[DATA_W-1:DATA_W-8];

   // Opcode decode
   always_comb begin
      dec_s = I_NOP;
      case (opcode_s)
         OP_LOAD:   dec_s = I_LOAD;
         OP_STORE:  dec_s = I_STORE;
         OP_MOVE:   dec_s = I_MOVE;
         OP_ADD:    dec_s = I_ADD;
         OP_SUB:    dec_s = I_SUB;
         OP_AND:    dec_s = I_AND;
         OP_OR:     dec_s = I_OR;
         OP_BRANCH: dec_s = I_BRANCH;
         OP_BZERO:  dec_s = I_BZERO;
         OP_BNZERO: dec_s = I_BNZERO;
         OP_BNEG:   dec_s = I_BNEG;
         OP_BNNEG:  dec_s = I_BNNEG;
         OP_HALT:   dec_s = I_HALT;
`ifdef KS_DP_MUL_EN
         OP_MUL:    dec_s = I_MUL;
`endif
         default:   dec_s = I_NOP;
      endcase
   end

   assign decoded_instruction = dec_s;

   // Operand field extraction; fields an instruction does not use stay zero
   always_comb begin
      a_s   = '0;
      b_s   = '0;
      c_s   = '0;
      mem_s = '0;
      case (dec_s)
         I_LOAD: begin
            mem_s = ir_r[ADDR_W-1:0];
            c_s   = ir_r[ADDR_W+RW-1:ADDR_W];
         end
         I_STORE: begin
            mem_s = ir_r[ADDR_W-1:0];
            a_s   = ir_r[ADDR_W+RW-1:ADDR_W];
         end
         I_MOVE: begin
            a_s = ir_r[RW-1:0];
            b_s = ir_r[RW-1:0];
            c_s = ir_r[2*RW-1:RW];
         end
         I_ADD, I_SUB, I_AND, I_OR, I_MUL: begin
            a_s = ir_r[RW-1:0];
            b_s = ir_r[2*RW-1:RW];
            c_s = ir_r[3*RW-1:2*RW];
         end
         I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
            mem_s = ir_r[ADDR_W-1:0];
         end
         default: begin
            mem_s = '0;
         end
      endcase
   end

   assign bus_a_s  = regs_r[a_s];
   assign bus_b_s  = regs_r[b_s];
   assign bus_c_s  = c_sel ? ula_out_s : data_in;
   assign ram_addr = addr_sel ? pc_r : mem_s;
   assign data_out = bus_a_s;

   // SUB reuses the adder as a + ~b + 1; MSB carry-in recovered from the sum bit
   assign sub_s             = (operation == ALU_SUB);
   assign b_eff_s           = sub_s ? ~bus_b_s : bus_b_s;
   assign {cout_s, sum_s}   = {1'b0, bus_a_s} + {1'b0, b_eff_s} + {{DATA_W{1'b0}}, sub_s};
   assign c_msb_s           = sum_s[DATA_W-1] ^ bus_a_s[DATA_W-1] ^ b_eff_s[DATA_W-1];

   // ALU result and overflow selection
   always_comb begin
      ula_out_s = bus_a_s & bus_b_s;
      uov_s     = 1'b0;
      sov_s     = 1'b0;
      case (operation)
         ALU_OR: begin
            ula_out_s = bus_a_s | bus_b_s;
         end
         ALU_ADD: begin
            ula_out_s = sum_s;
            uov_s     = cout_s;
            sov_s     = c_msb_s ^ cout_s;
         end
         ALU_SUB: begin
            ula_out_s = sum_s;
            uov_s     = ~cout_s;
            sov_s     = c_msb_s ^ cout_s;
         end
         ALU_MUL: begin
`ifdef KS_DP_MUL_EN
            ula_out_s = product_s[DATA_W-1:0];
            uov_s     = |product_s[2*DATA_W-1:DATA_W];
`else
            ula_out_s = {DATA_W{1'b0}};
`endif
         end
         default: begin
            ula_out_s = bus_a_s & bus_b_s;
         end
      endcase
   end

   // Instruction register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_r <= '0;
      end else if (ir_enable) begin
         ir_r <= data_in;
      end else begin
         ir_r <= ir_r;
      end
   end

   // Program counter, wraps naturally at 2^ADDR_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= '0;
      end else if (pc_enable) begin
         pc_r <= branch ? mem_s : (pc_r + ADDR_W'(1));
      end else begin
         pc_r <= pc_r;
      end
   end

   // Register file write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         regs_r[c_s] <= bus_c_s;
      end else begin
         regs_r[c_s] <= regs_r[c_s];
      end
   end

   // Status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
      end else if (fl_en_s) begin
         zero_op           <= (ula_out_s == {DATA_W{1'b0}});
         neg_op            <= ula_out_s[DATA_W-1];
         unsigned_overflow <= uov_s;
         signed_overflow   <= sov_s;
      end else begin
         zero_op           <= zero_op;
         neg_op            <= neg_op;
         unsigned_overflow <= unsigned_overflow;
         signed_overflow   <= signed_overflow;
      end
   end

endmodule
